// File: rtl/mem_io_responder_pkg.sv
// Shared constants and helpers for the memory/IO responder: IO window decode
// and the source select for the registered read-data output.
package mem_io_responder_pkg;

    localparam logic [1:0]  IO_PREFIX    = 2'b11;
    localparam logic [31:0] IO_UART_ADDR = 32'h0003_0000;
    localparam logic [31:0] IO_HALT_ADDR = 32'h0003_0004;
    localparam logic        TRUE         = 1'b1;
    localparam logic        FALSE        = 1'b0;

    typedef enum logic {
        DIN_SRC_IO  = 1'b0,
        DIN_SRC_RAM = 1'b1
    } din_src_e;

    function automatic logic is_io(input logic [31:0] addr);
        return addr[17:16] == IO_PREFIX;
    endfunction

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// UART transmit FIFO: small distributed array, wrap-around pointers, occupancy
// count and a registered near-full flag computed from the next count.
module io_tx_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       en,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       empty,
    output logic                       full,
    output logic                       near_full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          near_full_q, near_full_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop      = en && pop && (count_q != '0);
        // A pop in the same cycle frees a slot, so a push at full still lands.
        do_push     = en && push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d    = wr_ptr_q + PW'(do_push);
        rd_ptr_d    = rd_ptr_q + PW'(do_pop);
        count_d     = count_q + CW'(do_push) - CW'(do_pop);
        near_full_d = (count_d >= CW'(DEPTH - FULL_MARGIN));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            near_full_q <= FALSE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            near_full_q <= near_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout      = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign near_full = near_full_q;
    assign count     = count_q;

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the byte-serial bus: main RAM, IO window decode,
// UART TX FIFO / RX pop, sticky halt and overflow flags.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ack,
    output logic        tx_overflow,
    output logic        sim_halt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [7:0]            ram_rd_q;

    logic                  prev_io_q, prev_io_d;
    logic [31:0]           prev_a_q, prev_a_d;
    logic                  prev_wr_q, prev_wr_d;
    logic [7:0]            io_din_q, io_din_d;
    din_src_e              din_src_q, din_src_d;
    logic                  rx_ack_q, rx_ack_d;
    logic                  tx_overflow_q, tx_overflow_d;
    logic                  sim_halt_q, sim_halt_d;

    logic                  io_hit, io_first, uart_first;
    logic                  ram_rd, ram_we;
    logic                  tx_push, tx_pop, tx_drop, uart_rd, halt_wr, other_io_rd;
    logic                  fifo_empty, fifo_full, fifo_near_full;
    logic [CW-1:0]         fifo_count;

    assign ram_idx = mem_a[ADDR_WIDTH-1:0];

    always_comb begin
        io_hit      = is_io(mem_a);
        // The controller parks addr/wr while idle; only the first cycle of an
        // IO access may trigger side effects.
        io_first    = io_hit && !(prev_io_q && (prev_a_q == mem_a) && (prev_wr_q == mem_wr));
        uart_first  = io_first && (mem_a == IO_UART_ADDR);
        ram_rd      = rdy_in && !io_hit && !mem_wr;
        ram_we      = rdy_in && !io_hit && mem_wr;
        tx_push     = rdy_in && uart_first && mem_wr;
        uart_rd     = rdy_in && uart_first && !mem_wr;
        halt_wr     = rdy_in && io_first && mem_wr && (mem_a == IO_HALT_ADDR);
        other_io_rd = rdy_in && io_hit && !mem_wr && (mem_a != IO_UART_ADDR);
        tx_pop      = tx_ready && !fifo_empty;
        tx_drop     = tx_push && fifo_full && !tx_pop;

        prev_io_d     = prev_io_q;
        prev_a_d      = prev_a_q;
        prev_wr_d     = prev_wr_q;
        io_din_d      = io_din_q;
        din_src_d     = din_src_q;
        rx_ack_d      = rx_ack_q;
        tx_overflow_d = tx_overflow_q;
        sim_halt_d    = sim_halt_q;

        if (rdy_in) begin
            prev_io_d = io_hit;
            prev_a_d  = mem_a;
            prev_wr_d = mem_wr;
            rx_ack_d  = uart_rd && rx_valid;
        end
        if (ram_rd) begin
            din_src_d = DIN_SRC_RAM;
        end else if (uart_rd) begin
            din_src_d = DIN_SRC_IO;
            io_din_d  = rx_valid ? rx_data : 8'h00;
        end else if (other_io_rd) begin
            din_src_d = DIN_SRC_IO;
            io_din_d  = 8'h00;
        end
        if (tx_drop) begin
            tx_overflow_d = TRUE;
        end
        if (halt_wr) begin
            sim_halt_d = TRUE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prev_io_q     <= FALSE;
            prev_a_q      <= '0;
            prev_wr_q     <= FALSE;
            io_din_q      <= '0;
            din_src_q     <= DIN_SRC_IO;
            rx_ack_q      <= FALSE;
            tx_overflow_q <= FALSE;
            sim_halt_q    <= FALSE;
        end else begin
            prev_io_q     <= prev_io_d;
            prev_a_q      <= prev_a_d;
            prev_wr_q     <= prev_wr_d;
            io_din_q      <= io_din_d;
            din_src_q     <= din_src_d;
            rx_ack_q      <= rx_ack_d;
            tx_overflow_q <= tx_overflow_d;
            sim_halt_q    <= sim_halt_d;
        end
    end

    // Kept free of reset so the array and its read register map onto block RAM.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_dout;
        end
        if (ram_rd) begin
            ram_rd_q <= ram[ram_idx];
        end
    end

    io_tx_fifo #(
        .DEPTH       (FIFO_DEPTH),
        .FULL_MARGIN (FULL_MARGIN)
    ) u_tx_fifo (
        .clk       (clk_in),
        .srst      (rst_in),
        .en        (rdy_in),
        .push      (tx_push),
        .din       (mem_dout),
        .pop       (tx_pop),
        .dout      (tx_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .near_full (fifo_near_full),
        .count     (fifo_count)
    );

    assign mem_din        = (din_src_q == DIN_SRC_RAM) ? ram_rd_q : io_din_q;
    assign tx_valid       = (fifo_count != '0);
    assign io_buffer_full = fifo_near_full;
    assign rx_ack         = rx_ack_q;
    assign tx_overflow    = tx_overflow_q;
    assign sim_halt       = sim_halt_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: expected read bytes and TX bytes are
// queued as stimulus is driven and compared when the DUT presents them.
module tb_mem_io_responder;

    localparam logic [31:0] UART = 32'h0003_0000;
    localparam logic [31:0] HALT = 32'h0003_0004;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout, mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ack, tx_overflow, sim_halt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  rd_q[$];
    logic [7:0]  tx_q[$];
    logic        rd_issue = 1'b0;
    logic        rd_due   = 1'b0;

    always #5 clk_in = ~clk_in;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ack         (rx_ack),
        .tx_overflow    (tx_overflow),
        .sim_halt       (sim_halt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    // Read data is due one edge after the read address was presented.
    always @(posedge clk_in) rd_due <= rd_issue;

    always @(negedge clk_in) begin
        if (rd_due) begin
            if (rd_q.size() == 0) check("rd_q_nonempty", rd_q.size(), 1);
            else                  check("mem_din", {24'h0, mem_din}, {24'h0, rd_q.pop_front()});
        end
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) check("tx_q_nonempty", tx_q.size(), 1);
            else                  check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
        end
    end

    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        @(posedge clk_in);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        rd_issue = 1'b1;
        cyc(a, 1'b0, 8'h00);
        rd_issue = 1'b0;
    endtask

    // A non-IO cycle before each UART write gives it a fresh access edge.
    task automatic uart_wr(input logic [7:0] d, input logic accept);
        cyc(32'h0, 1'b0, 8'h00);
        cyc(UART, 1'b1, d);
        if (accept) tx_q.push_back(d);
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && tx_valid; i++) cyc(32'h0, 1'b0, 8'h00);
        tx_ready = 1'b0;
        check("tx_q_drained", tx_q.size(), 0);
        check("tx_valid_drained", {31'h0, tx_valid}, 0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        cyc(32'h0, 1'b0, 8'h00);
        rst_in = 1'b0;
        tx_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00;
        cyc(32'h0, 1'b0, 8'h00);
        cyc(32'h0, 1'b0, 8'h00);
        rst_in = 1'b0;
        check("rst_mem_din",     {24'h0, mem_din}, 0);
        check("rst_tx_valid",    {31'h0, tx_valid}, 0);
        check("rst_buf_full",    {31'h0, io_buffer_full}, 0);
        check("rst_rx_ack",      {31'h0, rx_ack}, 0);
        check("rst_tx_overflow", {31'h0, tx_overflow}, 0);
        check("rst_sim_halt",    {31'h0, sim_halt}, 0);

        // Single write then read-back one cycle later
        cyc(32'h10, 1'b1, 8'hA5);
        check("din_holds_on_write", {24'h0, mem_din}, 0);
        rd(32'h10, 8'hA5);

        // Burst write and incrementing read
        for (int i = 0; i < 4; i++) cyc(32'h100 + i, 1'b1, 8'(8'h11 * (i + 1)));
        for (int i = 0; i < 4; i++) rd(32'h100 + i, 8'(8'h11 * (i + 1)));
        rd(32'h10, 8'hA5);
        rd(32'h3_0008, 8'h00);

        // Held UART write pushes once; toggling wr re-arms the port
        cyc(32'h0, 1'b0, 8'h00);
        repeat (5) cyc(UART, 1'b1, 8'h41);
        tx_q.push_back(8'h41);
        rd(UART, 8'h00);
        check("rx_ack_no_valid", {31'h0, rx_ack}, 0);
        cyc(UART, 1'b1, 8'h42);
        tx_q.push_back(8'h42);
        drain();

        // RX pop, held read, empty read
        rx_valid = 1'b1; rx_data = 8'h5A;
        cyc(32'h0, 1'b0, 8'h00);
        rd(UART, 8'h5A);
        check("rx_ack_pulse", {31'h0, rx_ack}, 1);
        rd(UART, 8'h5A);
        check("rx_ack_held_read", {31'h0, rx_ack}, 0);
        rx_valid = 1'b0;
        cyc(32'h0, 1'b0, 8'h00);
        rd(UART, 8'h00);
        check("rx_ack_empty", {31'h0, rx_ack}, 0);

        // Fill to full, near-full at 6, ninth write dropped
        for (int i = 1; i <= 8; i++) begin
            uart_wr(8'(8'h60 + i), 1'b1);
            check($sformatf("buf_full_after_%0d", i), {31'h0, io_buffer_full}, (i >= 6) ? 1 : 0);
        end
        check("overflow_before", {31'h0, tx_overflow}, 0);
        uart_wr(8'h69, 1'b0);
        check("overflow_set", {31'h0, tx_overflow}, 1);
        check("buf_full_at_full", {31'h0, io_buffer_full}, 1);
        drain();
        check("buf_full_drained", {31'h0, io_buffer_full}, 0);

        // Fill again; ninth write with a simultaneous pop is accepted
        do_reset();
        for (int i = 1; i <= 8; i++) uart_wr(8'(8'h70 + i), 1'b1);
        cyc(32'h0, 1'b0, 8'h00);
        tx_ready = 1'b1;
        cyc(UART, 1'b1, 8'h79);
        tx_q.push_back(8'h79);
        tx_ready = 1'b0;
        check("overflow_push_pop", {31'h0, tx_overflow}, 0);
        check("buf_full_push_pop", {31'h0, io_buffer_full}, 1);
        uart_wr(8'h7A, 1'b0);
        check("count_stayed_full", {31'h0, tx_overflow}, 1);
        drain();

        // rdy_in low freezes RAM, FIFO and halt
        do_reset();
        cyc(32'h200, 1'b1, 8'h33);
        rdy_in = 1'b0;
        cyc(32'h200, 1'b1, 8'h77);
        cyc(32'h0, 1'b0, 8'h00);
        cyc(UART, 1'b1, 8'h99);
        cyc(HALT, 1'b1, 8'h01);
        rdy_in = 1'b1;
        check("frozen_sim_halt", {31'h0, sim_halt}, 0);
        check("frozen_tx_valid", {31'h0, tx_valid}, 0);
        rd(32'h200, 8'h33);
        cyc(HALT, 1'b1, 8'h01);
        check("sim_halt_set", {31'h0, sim_halt}, 1);

        // Reset with five entries queued discards them
        for (int i = 1; i <= 5; i++) uart_wr(8'(8'h80 + i), 1'b1);
        check("tx_valid_five", {31'h0, tx_valid}, 1);
        rst_in = 1'b1;
        cyc(UART, 1'b1, 8'h55);
        rst_in = 1'b0;
        tx_q.delete();
        check("rst2_tx_valid",    {31'h0, tx_valid}, 0);
        check("rst2_buf_full",    {31'h0, io_buffer_full}, 0);
        check("rst2_tx_overflow", {31'h0, tx_overflow}, 0);
        check("rst2_sim_halt",    {31'h0, sim_halt}, 0);
        check("rst2_rx_ack",      {31'h0, rx_ack}, 0);
        check("rst2_mem_din",     {24'h0, mem_din}, 0);
        tx_ready = 1'b1;
        repeat (3) cyc(32'h0, 1'b0, 8'h00);
        tx_ready = 1'b0;
        check("fifo_discarded", {31'h0, tx_valid}, 0);

        cyc(32'h0, 1'b0, 8'h00);
        check("rd_q_empty", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
